// File: rtl/cpu_datapath.sv
// 8-bit teaching-CPU datapath: register file, PC/AR/IR, ALU, flags and 256x8 memory.
// Define DP_BUS_CONFLICT_EN to build the sticky bus-conflict detector driving bus_err.
module cpu_datapath (
  input  logic       clk,
  input  logic       clr,
  input  logic       t3,
  input  logic [7:0] sd,
  input  logic       drw,
  input  logic       pcinc,
  input  logic       lpc,
  input  logic       lar,
  input  logic       pcadd,
  input  logic       arinc,
  input  logic       selctl,
  input  logic       memw,
  input  logic       lir,
  input  logic       ldz,
  input  logic       ldc,
  input  logic       cin,
  input  logic       m,
  input  logic       abus,
  input  logic       sbus,
  input  logic       mbus,
  input  logic       sel0,
  input  logic       sel1,
  input  logic       sel2,
  input  logic       sel3,
  input  logic [3:0] s,
  output logic [3:0] ir_hi,
  output logic       c,
  output logic       z,
  output logic [7:0] pc,
  output logic [7:0] ar,
  output logic [7:0] bus,
  output logic       bus_err
);

  logic [7:0] r_q [4];
  logic [7:0] mem [256];
  logic [7:0] pc_q, pc_d, ar_q, ar_d, ir_q;
  logic       c_q, z_q;

  logic [1:0] a_idx, b_idx;
  logic [7:0] a_val, b_val, b_op, alu_f, bus_val;
  logic [8:0] sum9;
  logic       arith, alu_co, commit;

  assign commit = t3;
  assign a_idx  = selctl ? {sel3, sel2} : ir_q[3:2];
  assign b_idx  = selctl ? {sel1, sel0} : ir_q[1:0];
  assign a_val  = r_q[a_idx];
  assign b_val  = r_q[b_idx];

  // Carry-in is active-low: cin=0 adds one.
  always_comb begin
    arith  = 1'b1;
    b_op   = 8'h00;
    alu_f  = a_val;
    alu_co = 1'b0;
    case (s)
      4'b1001: b_op = b_val;
      4'b0110: b_op = ~b_val;
      4'b0000: b_op = 8'h00;
      4'b1111: b_op = 8'hFF;
      default: arith = 1'b0;
    endcase
    sum9 = {1'b0, a_val} + {1'b0, b_op} + {8'd0, ~cin};
    if (!m) begin
      if (arith) begin
        alu_f  = sum9[7:0];
        alu_co = sum9[8];
      end
    end else begin
      case (s)
        4'b1011: alu_f = a_val & b_val;
        4'b1110: alu_f = a_val | b_val;
        4'b0110: alu_f = a_val ^ b_val;
        4'b1010: alu_f = b_val;
        4'b0000: alu_f = ~a_val;
        4'b1111: alu_f = a_val;
        default: alu_f = 8'h00;
      endcase
    end
  end

  always_comb begin
    if (mbus)      bus_val = mem[ar_q];
    else if (abus) bus_val = alu_f;
    else if (sbus) bus_val = sd;
    else           bus_val = 8'h00;
  end

  always_comb begin
    pc_d = pc_q;
    if (lpc)        pc_d = bus_val;
    else if (pcadd) pc_d = pc_q + {{4{ir_q[3]}}, ir_q[3:0]};
    else if (pcinc) pc_d = pc_q + 8'd1;
    ar_d = ar_q;
    if (lar)        ar_d = bus_val;
    else if (arinc) ar_d = ar_q + 8'd1;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      for (int i = 0; i < 4; i++) r_q[i] <= 8'h00;
      pc_q <= 8'h00;
      ar_q <= 8'h00;
      ir_q <= 8'h00;
      c_q  <= 1'b0;
      z_q  <= 1'b0;
    end else if (commit) begin
      if (drw) r_q[a_idx] <= bus_val;
      if (lir) ir_q <= mem[pc_q];
      if (ldc) c_q <= alu_co;
      if (ldz) z_q <= (alu_f == 8'h00);
      pc_q <= pc_d;
      ar_q <= ar_d;
    end
  end

  // Memory has no reset; clr only blocks the write.
  always_ff @(posedge clk) begin
    if (clr && commit && memw) mem[ar_q] <= bus_val;
  end

`ifdef DP_BUS_CONFLICT_EN
  logic bus_err_q;
  logic conflict;
  assign conflict = (abus & sbus) | (abus & mbus) | (sbus & mbus);
  always_ff @(posedge clk or negedge clr) begin
    if (!clr)                    bus_err_q <= 1'b0;
    else if (commit && conflict) bus_err_q <= 1'b1;
  end
  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign ir_hi = ir_q[7:4];
  assign c     = c_q;
  assign z     = z_q;
  assign pc    = pc_q;
  assign ar    = ar_q;
  assign bus   = bus_val;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed bench for cpu_datapath: per-cycle compare against an abstract model plus literal pins.
module tb_cpu_datapath;

  logic clk = 1'b0;
  logic clr, t3, drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, lir, ldz, ldc, cin, m;
  logic abus, sbus, mbus, sel0, sel1, sel2, sel3;
  logic [7:0] sd;
  logic [3:0] s;
  logic [3:0] ir_hi;
  logic       c, z, bus_err;
  logic [7:0] pc, ar, bus;

  cpu_datapath dut (
    .clk(clk), .clr(clr), .t3(t3), .sd(sd), .drw(drw), .pcinc(pcinc), .lpc(lpc), .lar(lar),
    .pcadd(pcadd), .arinc(arinc), .selctl(selctl), .memw(memw), .lir(lir), .ldz(ldz),
    .ldc(ldc), .cin(cin), .m(m), .abus(abus), .sbus(sbus), .mbus(mbus), .sel0(sel0),
    .sel1(sel1), .sel2(sel2), .sel3(sel3), .s(s), .ir_hi(ir_hi), .c(c), .z(z), .pc(pc),
    .ar(ar), .bus(bus), .bus_err(bus_err)
  );

  initial forever #5 clk = ~clk;

`ifdef DP_BUS_CONFLICT_EN
  localparam bit ConflictBuilt = 1'b1;
`else
  localparam bit ConflictBuilt = 1'b0;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  // Abstract model state
  int mr [4];
  int mmem [256];
  int mpc, mar, mir;
  bit mc, mz, merr;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int a_sel();
    return selctl ? (sel3 * 2 + sel2) : (mir / 4) % 4;
  endfunction

  function automatic int b_sel();
    return selctl ? (sel1 * 2 + sel0) : mir % 4;
  endfunction

  // Returns F + 256*carry.
  function automatic int model_alu();
    int a, b, k, r;
    a = mr[a_sel()];
    b = mr[b_sel()];
    k = cin ? 0 : 1;
    r = 0;
    if (!m) begin
      case (s)
        4'd9:    r = a + b + k;
        4'd6:    r = a + (255 - b) + k;
        4'd0:    r = a + k;
        4'd15:   r = a + 255 + k;
        default: r = a;
      endcase
    end else begin
      case (s)
        4'd11:   r = a & b;
        4'd14:   r = a | b;
        4'd6:    r = a ^ b;
        4'd10:   r = b;
        4'd0:    r = 255 - a;
        4'd15:   r = a;
        default: r = 0;
      endcase
    end
    return r;
  endfunction

  function automatic int model_bus();
    if (mbus) return mmem[mar];
    if (abus) return model_alu() % 256;
    if (sbus) return sd;
    return 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 4; i++) mr[i] = 0;
    mpc = 0; mar = 0; mir = 0; mc = 0; mz = 0; merr = 0;
  endtask

  task automatic model_commit();
    int b, f, npc, nar, off;
    b = model_bus();
    f = model_alu();
    off = (mir % 16 >= 8) ? (mir % 16) - 16 : mir % 16;
    npc = lpc ? b : pcadd ? (mpc + off + 256) % 256 : pcinc ? (mpc + 1) % 256 : mpc;
    nar = lar ? b : arinc ? (mar + 1) % 256 : mar;
    if (ConflictBuilt && (int'(abus) + int'(sbus) + int'(mbus) >= 2)) merr = 1;
    if (ldc) mc = (f >= 256);
    if (ldz) mz = (f % 256 == 0);
    if (lir) mir = mmem[mpc];
    if (memw) mmem[mar] = b;
    if (drw) mr[a_sel()] = b;
    mpc = npc;
    mar = nar;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check("pc", pc, 8'(mpc));
      check("ar", ar, 8'(mar));
      check("ir_hi", {4'h0, ir_hi}, 8'(mir / 16));
      check("c", {7'd0, c}, {7'd0, mc});
      check("z", {7'd0, z}, {7'd0, mz});
      check("bus", bus, 8'(model_bus()));
      check("bus_err", {7'd0, bus_err}, {7'd0, merr});
    end
  end

  task automatic idle();
    {t3, drw, pcinc, lpc, lar, pcadd, arinc, selctl, memw, lir, ldz, ldc, cin, m} = '0;
    {abus, sbus, mbus, sel0, sel1, sel2, sel3} = '0;
    sd = 8'h00;
    s  = 4'h0;
  endtask

  task automatic step();
    @(posedge clk);
    if (t3 && clr) model_commit();
    #1;
    idle();
  endtask

  task automatic load_reg(input logic [1:0] idx, input logic [7:0] val);
    idle(); selctl = 1; {sel3, sel2} = idx; sbus = 1; sd = val; drw = 1; t3 = 1;
    step();
  endtask

  task automatic peek_reg(input string name, input logic [1:0] idx, input logic [7:0] exp);
    idle(); selctl = 1; {sel3, sel2} = idx; m = 1; s = 4'b1111; abus = 1;
    #1 check(name, bus, exp);
  endtask

  task automatic read_mem(input string name, input logic [7:0] addr, input logic [7:0] exp);
    idle(); lar = 1; sbus = 1; sd = addr; t3 = 1; step();
    mbus = 1;
    #1 check(name, bus, exp);
  endtask

  initial begin
    idle();
    clr = 0;
    model_reset();
    #2 chk_en = 1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_pc", pc, 8'h00);
    check("rst_ar", ar, 8'h00);
    check("rst_bus", bus, 8'h00);
    clr = 1;

    // R1 <= sd via sbus
    idle(); selctl = 1; {sel3, sel2} = 2'b01; sbus = 1; drw = 1; sd = 8'h5A; t3 = 1;
    #1 check("sbus_bus", bus, 8'h5A);
    step();
    peek_reg("r1_5a", 2'd1, 8'h5A);

    // 0xFF + 0x01 with no carry-in
    load_reg(2'd0, 8'hFF);
    load_reg(2'd1, 8'h01);
    idle(); selctl = 1; {sel1, sel0} = 2'b01; s = 4'b1001; cin = 1; abus = 1; drw = 1;
    ldc = 1; ldz = 1; t3 = 1;
    step();
    peek_reg("r0_wrap", 2'd0, 8'h00);
    check("c_set", {7'd0, c}, 8'h01);
    check("z_set", {7'd0, z}, 8'h01);

    // AR load, memory write with increment
    idle(); lar = 1; sbus = 1; sd = 8'h10; t3 = 1; step();
    check("ar_10", ar, 8'h10);
    idle(); memw = 1; arinc = 1; sbus = 1; sd = 8'h33; t3 = 1; step();
    check("ar_11", ar, 8'h11);
    read_mem("mem_10", 8'h10, 8'h33);

    // Fetch and relative branch
    idle(); lar = 1; sbus = 1; sd = 8'h20; t3 = 1; step();
    idle(); memw = 1; sbus = 1; sd = 8'h9E; t3 = 1; step();
    idle(); lpc = 1; sbus = 1; sd = 8'h20; t3 = 1; step();
    idle(); lir = 1; pcinc = 1; t3 = 1; step();
    check("ir_hi_9", {4'h0, ir_hi}, 8'h09);
    check("pc_21", pc, 8'h21);
    idle(); pcadd = 1; t3 = 1; step();
    check("pc_1f", pc, 8'h1F);

    // ALU sweep with flag loads
    load_reg(2'd2, 8'hC3);
    load_reg(2'd3, 8'h5A);
    idle(); selctl = 1; {sel3, sel2} = 2'b10; {sel1, sel0} = 2'b11; abus = 1;
    s = 4'b0110; cin = 0;
    #1 check("sub_lit", bus, 8'h69);
    m = 1;
    #1 check("xor_lit", bus, 8'h99);
    m = 0; s = 4'b1001; cin = 1;
    #1 check("add_lit", bus, 8'h1D);
    for (int mi = 0; mi < 2; mi++)
      for (int si = 0; si < 16; si++)
        for (int ci = 0; ci < 2; ci++) begin
          idle(); selctl = 1; {sel3, sel2} = 2'b10; {sel1, sel0} = 2'b11;
          m = 1'(mi); s = 4'(si); cin = 1'(ci); abus = 1; ldc = 1; ldz = 1; t3 = 1;
          step();
        end

    // IR-selected operands: IR=0x9E gives A=R3, B=R2
    idle(); m = 1; s = 4'b1010; abus = 1;
    #1 check("irsel_b", bus, 8'hC3);

    // t3=0 leaves state alone
    idle(); lpc = 1; sbus = 1; sd = 8'h77; step();
    check("no_t3", pc, 8'h1F);

    // PC and AR wrap
    idle(); lpc = 1; lar = 1; sbus = 1; sd = 8'hFF; t3 = 1; step();
    idle(); pcinc = 1; arinc = 1; t3 = 1; step();
    check("pc_wrap", pc, 8'h00);
    check("ar_wrap", ar, 8'h00);

    // Asynchronous reset mid-cycle, commit during reset is aborted
    idle(); lpc = 1; sbus = 1; sd = 8'h42; t3 = 1; step();
    #2 clr = 0;
    model_reset();
    #1;
    check("arst_pc", pc, 8'h00);
    check("arst_irhi", {4'h0, ir_hi}, 8'h00);
    idle(); lpc = 1; sbus = 1; sd = 8'h77; t3 = 1; step();
    check("arst_hold", pc, 8'h00);
    clr = 1;
    peek_reg("arst_r3", 2'd3, 8'h00);
    read_mem("mem_keep", 8'h10, 8'h33);

    // Bus conflict
    idle(); abus = 1; sbus = 1; sd = 8'h11; t3 = 1; step();
    check("err_set", {7'd0, bus_err}, {7'd0, ConflictBuilt});
    idle(); sbus = 1; t3 = 1; step();
    check("err_sticky", {7'd0, bus_err}, {7'd0, ConflictBuilt});
    #2 clr = 0;
    model_reset();
    #1 check("err_clr", {7'd0, bus_err}, 8'h00);
    clr = 1;
    repeat (2) @(posedge clk);
    #1;
    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
